// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg
// Shared types and constants for the bit-serial subtractor.
//   state_t       : IDLE / RUN / DONE control states
//   SUB_WIDTH_DEF : default operand width
//   cnt_width()   : bit-counter width for a given operand width
package serial_sub_pkg;

    localparam int SUB_WIDTH_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Counter only has to reach WIDTH-1; keep at least one bit.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/full_subtractor_bit.sv
// full_subtractor_bit
// Combinational 1-bit full subtractor: x - y - bin.
//   x, y : operand bits
//   bin  : borrow in
//   d    : difference bit
//   bout : borrow out
module full_subtractor_bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = x ^ y ^ bin;
    // Borrow when x=0,y=1, or when x==y and a borrow propagates through.
    assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// serial_subtractor
// Bit-serial WIDTH-bit subtractor (A - B), LSB first, one full-subtractor
// cell reused every cycle. Start/busy/done handshake.
//   clk, rst   : clock, synchronous active-high reset
//   start      : request, sampled only in IDLE
//   a, b       : minuend / subtrahend, captured on accepted start
//   borrow_in  : initial borrow (only with SERIAL_SUB_BORROW_IN_EN)
//   busy       : high in RUN and DONE
//   done       : one-cycle result-valid pulse
//   diff       : A - B mod 2^WIDTH, held until next accepted start
//   borrow_out : final borrow, held with diff
// Build option: define SERIAL_SUB_BORROW_IN_EN to add the borrow_in port.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = SUB_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
    input  logic             borrow_in,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_a, r_b, r_diff;
    logic [CW-1:0]    r_cnt;
    logic             r_brw, r_bout;
    logic             w_d, w_bo, w_last, w_bin0;

`ifdef SERIAL_SUB_BORROW_IN_EN
    assign w_bin0 = borrow_in;
`else
    assign w_bin0 = 1'b0;
`endif

    assign w_last = (r_cnt == CW'(WIDTH - 1));

    full_subtractor_bit u_fs (
        .x    (r_a[0]),
        .y    (r_b[0]),
        .bin  (r_brw),
        .d    (w_d),
        .bout (w_bo)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state: start is only looked at in IDLE; DONE lasts one cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_next = RUN;
            RUN:     if (w_last) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_diff <= '0;
            r_cnt  <= '0;
            r_brw  <= 1'b0;
            r_bout <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    r_a    <= a;
                    r_b    <= b;
                    r_cnt  <= '0;
                    r_brw  <= w_bin0;
                    r_diff <= '0;
                end
                RUN: begin
                    // Result bits enter at the MSB; after WIDTH shifts the
                    // first (LSB) difference bit has reached bit 0.
                    r_diff <= {w_d, r_diff[WIDTH-1:1]};
                    r_a    <= {1'b0, r_a[WIDTH-1:1]};
                    r_b    <= {1'b0, r_b[WIDTH-1:1]};
                    r_brw  <= w_bo;
                    r_cnt  <= r_cnt + 1'b1;
                    if (w_last) r_bout <= w_bo;
                end
                default: ;
            endcase
        end
    end

    // Status decodes straight from the state register.
    assign busy       = (r_state != IDLE);
    assign done       = (r_state == DONE);
    assign diff       = r_diff;
    assign borrow_out = r_bout;

endmodule
